// File: rtl/serv_pkg.sv
// Shared constants and helpers for the wide SERV state/sequencer slice.
package serv_pkg;

  // Instruction width in bits; one full phase always covers this many bits.
  localparam int NBITS = 32;

  // Reset strategy selectors.
  localparam RST_MINI = "MINI";
  localparam RST_NONE = "NONE";

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bit index of the LSB of the last chunk in a phase.
  function automatic int cnt_last(input int w);
    return NBITS - w;
  endfunction

endpackage

// File: rtl/serv_state_cnt.sv
// Phase counter: running flag plus chunk index, with bit-position decode.
module serv_state_cnt
  import serv_pkg::*;
#(
  parameter int W              = 1,
  parameter     RESET_STRATEGY = RST_MINI
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rf_ready,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt2,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic [1:0] o_mem_bytecnt
);

  localparam int LW     = clog2(W);
  localparam int IW     = 5 - LW;
  localparam bit RST_EN = (RESET_STRATEGY != RST_NONE);

  logic          running_q, running_d;
  logic [IW-1:0] idx_q, idx_d;

  // LSB position of the chunk that contains bit k.
  function automatic logic [4:0] chunk_base(input int k);
    return 5'((k / W) * W);
  endfunction

  assign o_cnt_en   = running_q;
  assign o_cnt      = 5'(idx_q) << LW;
  assign o_cnt_done = running_q & (o_cnt == 5'(cnt_last(W)));

  assign o_cnt0        = running_q & (o_cnt == chunk_base(0));
  assign o_cnt1        = running_q & (o_cnt == chunk_base(1));
  assign o_cnt2        = running_q & (o_cnt == chunk_base(2));
  assign o_cnt3        = running_q & (o_cnt == chunk_base(3));
  assign o_cnt7        = running_q & (o_cnt == chunk_base(7));
  assign o_cnt0to3     = (o_cnt < 5'd4);
  assign o_cnt12to31   = (o_cnt >= 5'd12);
  assign o_mem_bytecnt = o_cnt[4:3];

  // Start on rf_ready when idle; step each cycle while running; the index
  // wraps to zero by itself on the last chunk. Reset aborts at once.
  always_comb begin
    running_d = running_q;
    idx_d     = idx_q;
    if (running_q) begin
      idx_d = idx_q + IW'(1);
      if (o_cnt_done) running_d = 1'b0;
    end else if (i_rf_ready) begin
      running_d = 1'b1;
      idx_d     = '0;
    end
    if (RST_EN && i_rst) begin
      running_d = 1'b0;
      idx_d     = '0;
    end
  end

  // Counter state register.
  always_ff @(posedge i_clk) begin
    running_q <= running_d;
    idx_q     <= idx_d;
  end

endmodule

// File: rtl/serv_state_wide.sv
// SERV state/sequencer, W bits per cycle: INIT/RUN sequencing, branch and
// misalign capture, and the ibus/dbus/RF request strobes.
module serv_state_wide
  import serv_pkg::*;
#(
  parameter int W              = 1,
  parameter     RESET_STRATEGY = RST_MINI,
  parameter int WITH_CSR       = 1,
  parameter int ALIGN          = 0,
  parameter int MDU            = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_new_irq,
  input  logic       i_alu_cmp,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  input  logic       i_sh_done,
  input  logic       i_sh_done_r,
  input  logic       i_bne_or_bge,
  input  logic       i_cond_branch,
  input  logic       i_dbus_en,
  input  logic       i_two_stage_op,
  input  logic       i_branch_op,
  input  logic       i_shift_op,
  input  logic       i_sh_right,
  input  logic       i_slt_or_branch,
  input  logic       i_e_op,
  input  logic       i_rd_op,
  input  logic       i_mdu_op,
  input  logic       i_mdu_ready,
  input  logic       i_dbus_ack,
  input  logic       i_ibus_ack,
  input  logic       i_rf_ready,
  output logic [4:0] o_cnt,
  output logic       o_cnt_en,
  output logic       o_cnt_done,
  output logic       o_init,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt2,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_bufreg_en,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic       o_mdu_valid,
  output logic       o_dbus_cyc,
  output logic       o_ibus_cyc,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  output logic       o_rf_rd_en
);

  localparam bit RST_EN   = (RESET_STRATEGY != RST_NONE);
  localparam bit CSR_EN   = (WITH_CSR != 0);
  localparam bit ALIGN_EN = (ALIGN != 0);
  localparam bit MDU_EN   = (MDU != 0);

  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
    $error("serv_state_wide: W must be 1, 2, 4 or 8");
  end

  logic init_done_q, init_done_d;
  logic ctrl_jump_q, ctrl_jump_d;
  logic stage_two_req_q, stage_two_req_d;
  logic misalign_q, misalign_d;
  logic ibus_cyc_q, ibus_cyc_d;
  logic misalign_r;
  logic take_branch;

  serv_state_cnt #(
    .W              (W),
    .RESET_STRATEGY (RESET_STRATEGY)
  ) u_cnt (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rf_ready    (i_rf_ready),
    .o_cnt_en      (o_cnt_en),
    .o_cnt         (o_cnt),
    .o_cnt_done    (o_cnt_done),
    .o_cnt0        (o_cnt0),
    .o_cnt1        (o_cnt1),
    .o_cnt2        (o_cnt2),
    .o_cnt3        (o_cnt3),
    .o_cnt7        (o_cnt7),
    .o_cnt0to3     (o_cnt0to3),
    .o_cnt12to31   (o_cnt12to31),
    .o_mem_bytecnt (o_mem_bytecnt)
  );

  // Without CSR support the misalign flag is tied low even if the flop
  // never sees a reset.
  assign misalign_r  = CSR_EN & misalign_q;
  assign take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));

  assign o_init       = i_two_stage_op & !i_new_irq & !init_done_q;
  assign o_ctrl_pc_en = o_cnt_en & !o_init;
  assign o_rf_rd_en   = i_rd_op & !o_init;
  assign o_ctrl_jump  = ctrl_jump_q;
  assign o_ctrl_trap  = CSR_EN & (i_e_op | i_new_irq | misalign_r);

  assign o_rf_wreq = !misalign_r & !o_cnt_en & init_done_q &
                     ((i_shift_op & (i_sh_done | !i_sh_right)) | i_dbus_ack |
                      (MDU_EN & i_mdu_ready) | i_slt_or_branch);
  assign o_rf_rreq   = i_ibus_ack | (stage_two_req_q & misalign_r);
  assign o_dbus_cyc  = !o_cnt_en & init_done_q & i_dbus_en & !i_mem_misalign;
  assign o_mdu_valid = MDU_EN & !o_cnt_en & init_done_q & i_mdu_op;
  assign o_ibus_cyc  = ibus_cyc_q & !i_rst;

  assign o_bufreg_en = (o_cnt_en & (o_init | ((o_ctrl_trap | i_branch_op) & i_two_stage_op))) |
                       (i_shift_op & !stage_two_req_q & (i_sh_right | i_sh_done_r) & init_done_q);

  // Capture INIT-phase outcomes at the end of a phase; the fetch strobe is
  // re-armed on ack, phase end or reset (reset forces it high so fetch
  // starts right after release). Reset overrides a coincident phase end.
  always_comb begin
    init_done_d     = init_done_q;
    ctrl_jump_d     = ctrl_jump_q;
    misalign_d      = misalign_q;
    ibus_cyc_d      = ibus_cyc_q;
    stage_two_req_d = o_cnt_done & o_init;
    if (o_cnt_done) begin
      init_done_d = o_init & !init_done_q;
      ctrl_jump_d = o_init & take_branch;
      misalign_d  = CSR_EN & o_init &
                    ((take_branch & i_ctrl_misalign & !ALIGN_EN) |
                     (i_dbus_en & i_mem_misalign));
    end
    if (i_ibus_ack | o_cnt_done | i_rst) ibus_cyc_d = o_ctrl_pc_en | i_rst;
    if (RST_EN && i_rst) begin
      init_done_d     = 1'b0;
      ctrl_jump_d     = 1'b0;
      misalign_d      = 1'b0;
      stage_two_req_d = 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    init_done_q     <= init_done_d;
    ctrl_jump_q     <= ctrl_jump_d;
    misalign_q      <= misalign_d;
    stage_two_req_q <= stage_two_req_d;
    ibus_cyc_q      <= ibus_cyc_d;
  end

endmodule

// File: tb/tb_serv_state_wide.sv
// Bench for serv_state_wide: one instance per legal W sharing the same
// stimulus, each compared every cycle against a phase-level model.
module tb_serv_state_wide;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst, i_new_irq, i_alu_cmp, i_ctrl_misalign, i_mem_misalign;
  logic i_sh_done, i_sh_done_r, i_bne_or_bge, i_cond_branch, i_dbus_en;
  logic i_two_stage_op, i_branch_op, i_shift_op, i_sh_right, i_slt_or_branch;
  logic i_e_op, i_rd_op, i_mdu_op, i_mdu_ready, i_dbus_ack, i_ibus_ack, i_rf_ready;

  logic [4:0] cnt_o [4];
  logic [1:0] bytecnt_o [4];
  logic cnt_en_o [4], done_o [4], init_o [4];
  logic c0_o [4], c1_o [4], c2_o [4], c3_o [4], c7_o [4], c0to3_o [4], c12_o [4];
  logic bufreg_o [4], pc_en_o [4], jump_o [4], trap_o [4], mdu_valid_o [4];
  logic dbus_cyc_o [4], ibus_cyc_o [4], rreq_o [4], wreq_o [4], rd_en_o [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serv_state_wide #(.W(1 << g)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_new_irq(i_new_irq), .i_alu_cmp(i_alu_cmp),
      .i_ctrl_misalign(i_ctrl_misalign), .i_mem_misalign(i_mem_misalign),
      .i_sh_done(i_sh_done), .i_sh_done_r(i_sh_done_r), .i_bne_or_bge(i_bne_or_bge),
      .i_cond_branch(i_cond_branch), .i_dbus_en(i_dbus_en), .i_two_stage_op(i_two_stage_op),
      .i_branch_op(i_branch_op), .i_shift_op(i_shift_op), .i_sh_right(i_sh_right),
      .i_slt_or_branch(i_slt_or_branch), .i_e_op(i_e_op), .i_rd_op(i_rd_op),
      .i_mdu_op(i_mdu_op), .i_mdu_ready(i_mdu_ready), .i_dbus_ack(i_dbus_ack),
      .i_ibus_ack(i_ibus_ack), .i_rf_ready(i_rf_ready),
      .o_cnt(cnt_o[g]), .o_cnt_en(cnt_en_o[g]), .o_cnt_done(done_o[g]), .o_init(init_o[g]),
      .o_cnt0(c0_o[g]), .o_cnt1(c1_o[g]), .o_cnt2(c2_o[g]), .o_cnt3(c3_o[g]),
      .o_cnt7(c7_o[g]), .o_cnt0to3(c0to3_o[g]), .o_cnt12to31(c12_o[g]),
      .o_mem_bytecnt(bytecnt_o[g]), .o_bufreg_en(bufreg_o[g]), .o_ctrl_pc_en(pc_en_o[g]),
      .o_ctrl_jump(jump_o[g]), .o_ctrl_trap(trap_o[g]), .o_mdu_valid(mdu_valid_o[g]),
      .o_dbus_cyc(dbus_cyc_o[g]), .o_ibus_cyc(ibus_cyc_o[g]), .o_rf_rreq(rreq_o[g]),
      .o_rf_wreq(wreq_o[g]), .o_rf_rd_en(rd_en_o[g])
    );
  end

  typedef struct packed {
    logic       cnt_en;
    logic [4:0] cnt;
    logic       done, init, c0, c1, c2, c3, c7, c0to3, c12;
    logic [1:0] bytecnt;
    logic       bufreg, pc_en, jump, trap, mdu_valid, dbus_cyc, ibus_cyc, rreq, wreq, rd_en;
  } obs_t;

  typedef struct {
    logic       ts, irq, e_op, rd_op, ack;
    logic [4:0] exp; // {init, trap, rd_en, rreq, pc_en}
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: per instance, whether a phase is running and how many
  // cycles into it we are, plus the captured INIT outcomes.
  bit m_run [4], m_idone [4], m_jump [4], m_s2r [4], m_mis [4], m_ibus [4];
  int m_k [4];

  function automatic obs_t dut_obs(input int g);
    obs_t a;
    a.cnt_en = cnt_en_o[g]; a.cnt = cnt_o[g]; a.done = done_o[g]; a.init = init_o[g];
    a.c0 = c0_o[g]; a.c1 = c1_o[g]; a.c2 = c2_o[g]; a.c3 = c3_o[g]; a.c7 = c7_o[g];
    a.c0to3 = c0to3_o[g]; a.c12 = c12_o[g]; a.bytecnt = bytecnt_o[g];
    a.bufreg = bufreg_o[g]; a.pc_en = pc_en_o[g]; a.jump = jump_o[g]; a.trap = trap_o[g];
    a.mdu_valid = mdu_valid_o[g]; a.dbus_cyc = dbus_cyc_o[g]; a.ibus_cyc = ibus_cyc_o[g];
    a.rreq = rreq_o[g]; a.wreq = wreq_o[g]; a.rd_en = rd_en_o[g];
    return a;
  endfunction

  function automatic bit holds(input int k, input int c, input int w);
    return (k >= c) && (k < c + w);
  endfunction

  function automatic obs_t model_obs(input int g);
    obs_t e;
    int w, n, c;
    bit init, trap;
    w = 1 << g;
    n = 32 / w;
    c = m_run[g] ? m_k[g] * w : 0;
    init = i_two_stage_op && !i_new_irq && !m_idone[g];
    trap = i_e_op || i_new_irq || m_mis[g];
    e = '0;
    e.cnt_en = m_run[g];
    e.cnt = 5'(c);
    e.done = m_run[g] && (m_k[g] == n - 1);
    e.init = init;
    e.c0 = m_run[g] && holds(0, c, w);
    e.c1 = m_run[g] && holds(1, c, w);
    e.c2 = m_run[g] && holds(2, c, w);
    e.c3 = m_run[g] && holds(3, c, w);
    e.c7 = m_run[g] && holds(7, c, w);
    e.c0to3 = (c < 4);
    e.c12 = (c >= 12);
    e.bytecnt = 2'(c / 8);
    e.bufreg = (m_run[g] && (init || ((trap || i_branch_op) && i_two_stage_op))) ||
               (i_shift_op && !m_s2r[g] && (i_sh_right || i_sh_done_r) && m_idone[g]);
    e.pc_en = m_run[g] && !init;
    e.jump = m_jump[g];
    e.trap = trap;
    e.mdu_valid = 1'b0;
    e.dbus_cyc = !m_run[g] && m_idone[g] && i_dbus_en && !i_mem_misalign;
    e.ibus_cyc = m_ibus[g] && !i_rst;
    e.rreq = i_ibus_ack || (m_s2r[g] && m_mis[g]);
    e.wreq = !m_mis[g] && !m_run[g] && m_idone[g] &&
             ((i_shift_op && (i_sh_done || !i_sh_right)) || i_dbus_ack || i_slt_or_branch);
    e.rd_en = i_rd_op && !init;
    return e;
  endfunction

  task automatic model_update();
    for (int g = 0; g < 4; g++) begin
      obs_t e;
      bit tb;
      e = model_obs(g);
      tb = i_branch_op && (!i_cond_branch || (i_alu_cmp ^ i_bne_or_bge));
      if (i_rst) begin
        m_run[g] = 0; m_k[g] = 0; m_idone[g] = 0; m_jump[g] = 0;
        m_s2r[g] = 0; m_mis[g] = 0; m_ibus[g] = 1;
      end else begin
        m_s2r[g] = e.done && e.init;
        if (e.done) begin
          m_idone[g] = e.init && !m_idone[g];
          m_jump[g] = e.init && tb;
          m_mis[g] = e.init && ((tb && i_ctrl_misalign) || (i_dbus_en && i_mem_misalign));
        end
        if (i_ibus_ack || e.done) m_ibus[g] = e.pc_en;
        if (m_run[g]) begin
          if (e.done) begin m_run[g] = 0; m_k[g] = 0; end
          else m_k[g] = m_k[g] + 1;
        end else if (i_rf_ready) begin
          m_run[g] = 1; m_k[g] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int g = 0; g < 4; g++) begin
      obs_t a, e;
      a = dut_obs(g);
      e = model_obs(g);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model_w%0d t=%0t: got %h want %h", 1 << g, $time, a, e);
      end
    end
  endtask

  task automatic check1(input string name, input int g, input logic [31:0] act,
                        input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s w=%0d t=%0t: got %0h want %0h", name, 1 << g, $time, act, exp);
    end
  endtask

  // One clock: compare against the model, take the edge, advance the model.
  task automatic step();
    #1;
    if (chk_en) check_model();
    @(posedge i_clk);
    model_update();
    chk_en = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic clear_inputs();
    {i_new_irq, i_alu_cmp, i_ctrl_misalign, i_mem_misalign, i_sh_done, i_sh_done_r,
     i_bne_or_bge, i_cond_branch, i_dbus_en, i_two_stage_op, i_branch_op, i_shift_op,
     i_sh_right, i_slt_or_branch, i_e_op, i_rd_op, i_mdu_op, i_mdu_ready, i_dbus_ack,
     i_ibus_ack, i_rf_ready} = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic start_phase();
    i_rf_ready = 1'b1;
    step();
    i_rf_ready = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{ts:0, irq:0, e_op:0, rd_op:0, ack:0, exp:5'b00000};
    vecs[1] = '{ts:1, irq:0, e_op:0, rd_op:1, ack:0, exp:5'b10000};
    vecs[2] = '{ts:1, irq:1, e_op:0, rd_op:1, ack:0, exp:5'b01100};
    vecs[3] = '{ts:0, irq:0, e_op:1, rd_op:1, ack:1, exp:5'b01110};
    vecs[4] = '{ts:1, irq:0, e_op:1, rd_op:0, ack:1, exp:5'b11010};
    vecs[5] = '{ts:0, irq:1, e_op:0, rd_op:0, ack:0, exp:5'b01000};

    clear_inputs();
    i_rst = 1'b1;
    @(negedge i_clk);
    do_reset();

    // Idle-state combinational decode table.
    for (int v = 0; v < 6; v++) begin
      i_two_stage_op = vecs[v].ts; i_new_irq = vecs[v].irq; i_e_op = vecs[v].e_op;
      i_rd_op = vecs[v].rd_op; i_ibus_ack = vecs[v].ack;
      #1;
      for (int g = 0; g < 4; g++)
        check1($sformatf("table%0d", v), g,
               32'({init_o[g], trap_o[g], rd_en_o[g], rreq_o[g], pc_en_o[g]}),
               32'(vecs[v].exp));
      step();
    end

    // Count length and position flags.
    clear_inputs();
    do_reset();
    start_phase();
    for (int j = 1; j <= 33; j++) begin
      for (int g = 0; g < 4; g++) begin
        int n, w, c;
        w = 1 << g;
        n = 32 / w;
        c = (j <= n) ? (j - 1) * w : 0;
        check1("count", g, 32'({cnt_en_o[g], cnt_o[g], done_o[g]}),
               32'({(j <= n), 5'(c), (j == n)}));
        if (g == 2)
          check1("flags", g, 32'({c0_o[g], c1_o[g], c2_o[g], c3_o[g], c7_o[g], c12_o[g]}),
                 32'({{4{j == 1}}, (j == 2), (c >= 12)}));
      end
      step();
    end

    // Taken conditional branch, W = 2.
    clear_inputs();
    do_reset();
    i_two_stage_op = 1; i_branch_op = 1; i_cond_branch = 1; i_alu_cmp = 1;
    i_bne_or_bge = 0; i_shift_op = 1; i_sh_right = 1;
    start_phase();
    for (int j = 1; j <= 18; j++) begin
      #1;
      if (j == 16) check1("br_done", 1, 32'({done_o[1], init_o[1], jump_o[1]}), 32'b110);
      if (j == 17) check1("br_after", 1, 32'({jump_o[1], init_o[1], bufreg_o[1]}), 32'b100);
      if (j == 18) check1("br_s2r_end", 1, 32'({jump_o[1], bufreg_o[1]}), 32'b11);
      step();
    end

    // Misaligned load, W = 8.
    clear_inputs();
    do_reset();
    i_two_stage_op = 1; i_dbus_en = 1; i_mem_misalign = 1; i_slt_or_branch = 1;
    start_phase();
    for (int j = 1; j <= 6; j++) begin
      #1;
      if (j == 4) check1("mis_done", 3, 32'({done_o[3], init_o[3], trap_o[3]}), 32'b110);
      if (j == 5)
        check1("mis_s2", 3, 32'({trap_o[3], dbus_cyc_o[3], rreq_o[3], wreq_o[3]}), 32'b1010);
      if (j == 6)
        check1("mis_s2_end", 3, 32'({trap_o[3], dbus_cyc_o[3], rreq_o[3], wreq_o[3]}), 32'b1000);
      step();
    end

    // Fetch handshake.
    clear_inputs();
    do_reset();
    #1;
    for (int g = 0; g < 4; g++) check1("fetch_start", g, 32'(ibus_cyc_o[g]), 32'd1);
    i_ibus_ack = 1;
    #1;
    for (int g = 0; g < 4; g++) check1("fetch_ack_rreq", g, 32'(rreq_o[g]), 32'd1);
    step();
    i_ibus_ack = 0;
    #1;
    for (int g = 0; g < 4; g++) check1("fetch_drop", g, 32'(ibus_cyc_o[g]), 32'd0);
    start_phase();
    for (int j = 1; j <= 33; j++) begin
      for (int g = 0; g < 4; g++) begin
        int n;
        n = 32 >> g;
        if (j == n) check1("fetch_wait", g, 32'(ibus_cyc_o[g]), 32'd0);
        if (j == n + 1) check1("fetch_rearm", g, 32'(ibus_cyc_o[g]), 32'd1);
      end
      step();
    end

    // Reset in the middle of a W = 1 phase.
    clear_inputs();
    do_reset();
    i_two_stage_op = 1; i_branch_op = 1;
    start_phase();
    repeat (16) step();
    #1;
    check1("pre_rst_cnt", 0, 32'({cnt_en_o[0], cnt_o[0]}), 32'({1'b1, 5'd16}));
    check1("pre_rst_jump", 1, 32'(jump_o[1]), 32'd1);
    i_rst = 1;
    #1;
    check1("rst_ibus_mask", 0, 32'(ibus_cyc_o[0]), 32'd0);
    step();
    i_rst = 0;
    #1;
    check1("rst_abort", 0, 32'({cnt_en_o[0], cnt_o[0], done_o[0], jump_o[0]}), 32'd0);
    check1("rst_jump_clr", 1, 32'(jump_o[1]), 32'd0);
    for (int j = 0; j < 40; j++) begin
      check1("rst_no_done", 0, 32'({cnt_en_o[0], done_o[0]}), 32'd0);
      step();
    end

    // Randomised traffic against the model.
    clear_inputs();
    do_reset();
    repeat (3000) begin
      i_rst = ($urandom_range(0, 63) == 0);
      i_rf_ready = ($urandom_range(0, 3) == 0);
      i_ibus_ack = ($urandom_range(0, 3) == 0);
      i_new_irq = ($urandom_range(0, 7) == 0);
      {i_alu_cmp, i_ctrl_misalign, i_mem_misalign, i_sh_done, i_sh_done_r, i_bne_or_bge,
       i_cond_branch, i_dbus_en, i_two_stage_op, i_branch_op, i_shift_op, i_sh_right,
       i_slt_or_branch, i_e_op, i_rd_op, i_mdu_op, i_mdu_ready, i_dbus_ack} = 18'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_state_wide.md
Name: serv_state_wide

Overview:
Parametrised successor of the SERV state/sequencer block. It serialises a 32-bit instruction over 32/W cycles, where W bits are processed per cycle (W = 1, 2, 4 or 8). It sits between the decoder, ALU/bufreg, RF interface and the ibus/dbus ports. It owns the two-stage INIT/RUN sequencing, branch/jump and misalign-trap capture, and the fetch/data bus request strobes.

Parameters:
- W, 1, bits processed per cycle. Legal values: 1, 2, 4, 8. Any other value triggers an elaboration error.
- RESET_STRATEGY, "MINI", value "NONE" skips reset of all state except ibus_cyc.
- WITH_CSR, 1, enables trap generation and misalign capture.
- ALIGN, 0, when 1, misaligned jump targets do not trap.
- MDU, 0, enables MDU valid/ready handling.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_new_irq, i_alu_cmp, i_ctrl_misalign, i_mem_misalign  in  1 each  status inputs
- i_sh_done, i_sh_done_r  in  1 each  shifter status
- i_bne_or_bge, i_cond_branch, i_dbus_en, i_two_stage_op, i_branch_op, i_shift_op, i_sh_right, i_slt_or_branch, i_e_op, i_rd_op, i_mdu_op  in  1 each  decoder controls
- i_mdu_ready, i_dbus_ack, i_ibus_ack, i_rf_ready  in  1 each  handshakes
- o_cnt  out  5  bit index of the LSB of the current chunk; steps by W
- o_cnt_en, o_cnt_done, o_init  out  1 each  sequencing status
- o_cnt0, o_cnt1, o_cnt2, o_cnt3, o_cnt7, o_cnt0to3, o_cnt12to31  out  1 each  position flags
- o_mem_bytecnt  out  2  byte counter (o_cnt[4:3])
- o_bufreg_en, o_ctrl_pc_en, o_ctrl_jump, o_ctrl_trap, o_mdu_valid  out  1 each  datapath controls
- o_dbus_cyc, o_ibus_cyc, o_rf_rreq, o_rf_wreq, o_rf_rd_en  out  1 each  bus/RF requests

Behaviour:
- **Phase length** N = 32/W cycles. The counter is a running flag plus a (5 − log2 W)-bit chunk index. o_cnt = index × W.
- **Start:** i_rf_ready high while o_cnt_en = 0 at edge t → o_cnt_en = 1 and o_cnt = 0 from t+1.
- **Run and stop:** o_cnt_done = 1 at t+N (o_cnt = 32 − W). o_cnt_en drops at t+N+1 and o_cnt wraps to 0.
- **Ignored start:** i_rf_ready while o_cnt_en = 1 has no effect; no restart and no extension.
- **Position flags:**
  - o_cntK (K = 0, 1, 2, 3, 7) is high when o_cnt_en = 1 and the current chunk contains bit K. For W = 4, cnt0..cnt3 are high in the same cycle.
  - o_cnt0to3 = (o_cnt < 4).
  - o_cnt12to31 = (o_cnt ≥ 12).
  - o_mem_bytecnt = o_cnt[4:3].
- **Derived controls:**
  - o_init = i_two_stage_op & !i_new_irq & !init_done.
  - o_ctrl_pc_en = o_cnt_en & !o_init.
  - o_rf_rd_en = i_rd_op & !o_init.
- **Branch:** take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge)).
- **Registers updated on o_cnt_done:**
  - init_done ← o_init & !init_done
  - o_ctrl_jump ← o_init & take_branch
  - misalign_r ← o_init & ((take_branch & i_ctrl_misalign & !ALIGN) | (i_dbus_en & i_mem_misalign)), only when WITH_CSR; otherwise misalign_r is constant 0.
- **stage_two_req** ← o_cnt_done & o_init, every cycle; it is a 1-cycle strobe.
- **Stage-two requests:**
  - o_rf_wreq = !misalign_r & !o_cnt_en & init_done & ((i_shift_op & (i_sh_done | !i_sh_right)) | i_dbus_ack | (MDU & i_mdu_ready) | i_slt_or_branch).
  - o_rf_rreq = i_ibus_ack | (stage_two_req & misalign_r).
  - o_dbus_cyc = !o_cnt_en & init_done & i_dbus_en & !i_mem_misalign.
  - o_mdu_valid = MDU & !o_cnt_en & init_done & i_mdu_op.
- **o_bufreg_en** = (o_cnt_en & (o_init | ((o_ctrl_trap | i_branch_op) & i_two_stage_op))) | (i_shift_op & !stage_two_req & (i_sh_right | i_sh_done_r) & init_done).
- **o_ctrl_trap** = WITH_CSR & (i_e_op | i_new_irq | misalign_r).
- **ibus_cyc:** when (i_ibus_ack | o_cnt_done | i_rst), ibus_cyc ← o_ctrl_pc_en | i_rst. o_ibus_cyc = ibus_cyc & !i_rst. Fetch therefore starts on the first cycle after reset release.
- **Reset** (unless RESET_STRATEGY = "NONE") clears: counter, running flag, init_done, o_ctrl_jump, stage_two_req, misalign_r. Reset mid-phase aborts the count immediately; o_cnt_en = 0 on the next cycle.
- **Simultaneous o_cnt_done & i_rst:** reset wins.
- **Simultaneous i_ibus_ack & o_cnt_done:** a single update of ibus_cyc ← o_ctrl_pc_en.

Decomposition:
- Package serv_pkg:
  - localparam function clog2.
  - constants NBITS = 32 and CNT_LAST(W) = 32 − W.
  - RESET_STRATEGY string constants.
- One sub-module, serv_state_cnt (W): running flag, chunk counter, o_cnt, o_cnt_done and position-flag decode.
- All handshake, trap and branch logic stays in the top module.

Test Plan:
- **Count length:** W = 1/2/4/8; pulse i_rf_ready at cycle 10 → o_cnt_en high for cycles 11..10+32/W; o_cnt_done only at cycle 42/26/18/14; o_cnt = 0, W, 2W, …
- **Position flags, W = 4:** o_cnt0..o_cnt3 all high in cycle 11 only; o_cnt7 high only at o_cnt = 4; o_cnt12to31 high from o_cnt = 12.
- **Taken branch, W = 2:** i_two_stage_op = 1, i_branch_op = 1, i_cond_branch = 1, i_alu_cmp = 1, i_bne_or_bge = 0 → at o_cnt_done: o_ctrl_jump = 1, init_done = 1, stage_two_req pulses 1 cycle, o_init falls.
- **Misaligned load, W = 8:** i_dbus_en = 1, i_mem_misalign = 1 through INIT → misalign_r = 1, o_ctrl_trap = 1, o_dbus_cyc stays 0, o_rf_rreq pulses with stage_two_req, o_rf_wreq = 0.
- **Fetch handshake:** release i_rst → o_ibus_cyc = 1 next cycle; i_ibus_ack → o_ibus_cyc = 0 and o_rf_rreq = 1 that cycle; a RUN-phase o_cnt_done with o_ctrl_pc_en = 1 → o_ibus_cyc = 1.
- **Reset mid-count:** assert i_rst at o_cnt = 16 (W = 1) → next cycle o_cnt = 0, o_cnt_en = 0, o_ctrl_jump = 0, no o_cnt_done pulse.
